// File: rtl/watchdog_reset_ctrl.sv
// Multi-channel watchdog: per-channel idle counters, a stretched system reset pulse with
// hold-off, per-channel early-warning flags and a sticky reset-cause record.
module watchdog_reset_ctrl #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned RST_PULSE_CYC = 16,
  parameter int unsigned HOLDOFF_CYC   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_kick,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic [CNT_W-1:0]  cfg_warn,
  input  logic [NUM_CH-1:0] cause_clr,
  output logic [NUM_CH-1:0] warn,
  output logic [NUM_CH-1:0] reset_cause,
  output logic              reset_signal,
  output logic              busy
);

  localparam int unsigned TMR_MAX   = (RST_PULSE_CYC > HOLDOFF_CYC) ? RST_PULSE_CYC : HOLDOFF_CYC;
  localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned PULSE_LD  = (RST_PULSE_CYC > 0) ? RST_PULSE_CYC - 1 : 0;
  localparam int unsigned HOLD_LD   = (HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              reset_signal_d;
  logic              busy_d;
  logic [NUM_CH-1:0] cause_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] warn_d;
  logic [NUM_CH-1:0] expire_c;
  logic              warn_on_c;

  assign warn_on_c = (cfg_warn != '0) && (cfg_warn < cfg_timeout);

  // Per-channel counters; anything other than an unkicked, enabled channel in IDLE clears to 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = '0;
      warn_d[i]   = 1'b0;
      expire_c[i] = 1'b0;
      if ((state_q == ST_IDLE) && ch_enable[i] && !ch_kick[i]) begin
        if ((cfg_timeout != '0) && (cnt_q[i] == cfg_timeout - CNT_W'(1))) begin
          expire_c[i] = 1'b1;
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
        warn_d[i] = warn_on_c && (cnt_d[i] >= cfg_warn);
      end
    end
  end

  // Pulse/hold-off sequencer.
  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    reset_signal_d = reset_signal;
    unique case (state_q)
      ST_IDLE: begin
        if (|expire_c) begin
          state_d        = ST_ASSERT;
          tmr_d          = TMR_W'(PULSE_LD);
          reset_signal_d = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (tmr_q == '0) begin
          reset_signal_d = 1'b0;
          if (HOLDOFF_CYC > 0) begin
            state_d = ST_HOLDOFF;
            tmr_d   = TMR_W'(HOLD_LD);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d        = ST_IDLE;
        reset_signal_d = 1'b0;
      end
    endcase
  end

  assign busy_d  = (state_d != ST_IDLE);
  // Newly expiring channels win over a simultaneous clear of the same bit.
  assign cause_d = (reset_cause & ~cause_clr) | expire_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      reset_signal <= 1'b0;
      busy         <= 1'b0;
      reset_cause  <= '0;
      warn         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      reset_signal <= reset_signal_d;
      busy         <= busy_d;
      reset_cause  <= cause_d;
      warn         <= warn_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_watchdog_reset_ctrl.sv
// Bench for watchdog_reset_ctrl: a cycle model predicts every output after each edge,
// a negedge monitor pops and compares against the DUT.
module tb_watchdog_reset_ctrl;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned P_CYC  = 16;
  localparam int unsigned H_CYC  = 64;

  typedef struct packed {
    logic              rs;
    logic              busy;
    logic [NUM_CH-1:0] warn;
    logic [NUM_CH-1:0] cause;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_enable, ch_kick, cause_clr;
  logic [CNT_W-1:0]  cfg_timeout, cfg_warn;
  logic [NUM_CH-1:0] warn, reset_cause;
  logic              reset_signal, busy;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Model: blocked edges remaining after an expiry, first P_CYC of them with reset high.
  longint            m_cnt [NUM_CH];
  int                m_blk   = 0;
  logic [NUM_CH-1:0] m_warn  = '0;
  logic [NUM_CH-1:0] m_cause = '0;

  watchdog_reset_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_PULSE_CYC(P_CYC), .HOLDOFF_CYC(H_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_enable(ch_enable), .ch_kick(ch_kick),
    .cfg_timeout(cfg_timeout), .cfg_warn(cfg_warn), .cause_clr(cause_clr),
    .warn(warn), .reset_cause(reset_cause), .reset_signal(reset_signal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    longint to, wv, sat;
    logic [NUM_CH-1:0] expv;
    to   = longint'(cfg_timeout);
    wv   = longint'(cfg_warn);
    sat  = (longint'(1) << CNT_W) - 1;
    expv = '0;
    if (m_blk > 0) begin
      m_blk--;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_warn = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_enable[i] || ch_kick[i]) begin
          m_cnt[i] = 0;
        end else if (to != 0 && m_cnt[i] + 1 == to) begin
          expv[i]  = 1'b1;
          m_cnt[i] = 0;
        end else if (m_cnt[i] < sat) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        m_warn[i] = ch_enable[i] && !ch_kick[i] && wv != 0 && wv < to && m_cnt[i] >= wv;
      end
      if (expv != '0) m_blk = P_CYC + H_CYC;
    end
    m_cause = (m_cause & ~cause_clr) | expv;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_blk   = 0;
        m_warn  = '0;
        m_cause = '0;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        q.delete();
      end else begin
        model_step();
        q.push_back('{rs: (m_blk > int'(H_CYC)), busy: (m_blk > 0), warn: m_warn, cause: m_cause});
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("reset_signal", 32'(reset_signal), 32'(e.rs));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("warn", 32'(warn), 32'(e.warn));
        chk("reset_cause", 32'(reset_cause), 32'(e.cause));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_blk != 0 && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (m_blk != 0) begin
      errors++;
      $display("FAIL wait_idle: blocked %0d still, required 0", m_blk);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_reset_signal"}, 32'(reset_signal), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_warn"}, 32'(warn), 32'd0);
    chk({tag, "_reset_cause"}, 32'(reset_cause), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ch_enable = '0; ch_kick = '0; cause_clr = '0;
    cfg_timeout = 32'd10; cfg_warn = 32'd0;
    #1;
    check_zero("por");
    step(3); rst_n = 1'b1; step(2);

    // T1: single channel, no kicks.
    ch_enable = 4'b0001; step(40);

    // T2: kick ch0 every 9 cycles, never expires.
    wait_idle(200);
    ch_enable = '0; step(1); ch_enable = 4'b0001;
    for (int c = 0; c < 200; c++) begin
      ch_kick = (c % 9 == 8) ? 4'b0001 : 4'b0000;
      step(1);
    end
    ch_kick = '0;

    // T3: warning threshold.
    cfg_warn = 32'd6; ch_enable = '0; step(1); ch_enable = 4'b0001; step(30);

    // T4: two channels expire together, clear of one bit on the same edge.
    wait_idle(200);
    ch_enable = '0; cause_clr = '1; step(1); cause_clr = '0;
    ch_enable = 4'b0110; step(9);
    cause_clr = 4'b0010; step(1); cause_clr = '0;
    step(100);

    // T5: ch0 left unkicked through hold-off, repeated pulses.
    ch_enable = 4'b0001; step(200);

    // T6: async reset in the middle of the pulse.
    n = 0;
    while (!(m_blk > int'(H_CYC) + 4) && n < 200) begin step(1); n++; end
    checks++;
    if (!(m_blk > int'(H_CYC) + 4)) begin
      errors++;
      $display("FAIL wait_assert: blocked %0d, required > %0d", m_blk, H_CYC + 4);
    end
    rst_n = 1'b0; #1;
    check_zero("async");
    step(2); rst_n = 1'b1; step(30);

    // T7: timeout lowered below the running count.
    wait_idle(200);
    ch_enable = '0; cfg_warn = 32'd0; cfg_timeout = 32'd30; step(1);
    ch_enable = 4'b0001; step(20);
    cfg_timeout = 32'd10; step(60);

    // Random traffic.
    cfg_timeout = 32'd12; cfg_warn = 32'd5; ch_enable = '1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        cfg_timeout = 32'($urandom_range(0, 20));
        cfg_warn    = 32'($urandom_range(0, 25));
      end
      if ($urandom_range(0, 63) == 0) ch_enable = NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) ch_kick[i] = ($urandom_range(0, 11) == 0);
      cause_clr = ($urandom_range(0, 31) == 0) ? NUM_CH'($urandom) : '0;
      if (c == 1500) begin
        rst_n = 1'b0; step(1); rst_n = 1'b1;
      end
      step(1);
    end
    ch_kick = '0; cause_clr = '0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
